imem_arbiter: RTL and testbench

- Shares the single-ported 32K x 48-bit instruction memory between two requesters.
- Port 0 is the CPU instruction fetch unit; port 1 is the debug/monitor instruction-read path.
- Sits between the requesters and imemory.
- Drives imemory's address/read inputs and routes its data/done back to the granted requester.
- Enforces the memory's read protocol:
  - read held high until done;
  - then read low for at least one cycle before the next access.

---
 rtl/mesm6_imem_pkg.sv | 16 +
 rtl/imem_arb_pick.sv | 26 ++
 rtl/imem_arbiter.sv | 100 ++++++++++
 tb/tb_imem_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mesm6_imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
package mesm6_imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } imem_arb_state_t;

    localparam int PORT_FETCH = 0;
    localparam int PORT_DEBUG = 1;

    localparam int IMEM_AW = 15;
    localparam int IMEM_DW = 48;

endpackage

// File: rtl/imem_arb_pick.sv
// Combinational winner select for the two instruction-memory requesters.
// Returns a one-hot grant; never 2'b11.
module imem_arb_pick
    import mesm6_imem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       rr_en,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req[PORT_FETCH] && req[PORT_DEBUG]) begin
            // last == 0 means the fetch port owned the previous access.
            if (rr_en && !last) begin
                grant[PORT_DEBUG] = 1'b1;
            end else begin
                grant[PORT_FETCH] = 1'b1;
            end
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Two-port arbiter in front of the single-ported instruction memory.
// Define IMEM_ARBITER_RR_EN for round-robin tie-breaking; default is fixed priority to port 0.
module imem_arbiter
    import mesm6_imem_pkg::*;
#(
    parameter int AW = IMEM_AW,
    parameter int DW = IMEM_DW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_req0,
    input  logic [AW-1:0] i_addr0,
    output logic          o_done0,
    output logic [DW-1:0] o_data0,
    input  logic          i_req1,
    input  logic [AW-1:0] i_addr1,
    output logic          o_done1,
    output logic [DW-1:0] o_data1,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_read,
    input  logic [DW-1:0] i_mem_data,
    input  logic          i_mem_done,
    output logic [1:0]    o_grant
);

    imem_arb_state_t state_reg;
    logic [AW-1:0]   mem_addr_reg;
    logic            mem_read_reg;
    logic [1:0]      grant_reg;
    logic [1:0]      pick_grant;
    logic            last_reg;
    logic            rr_en;

`ifdef IMEM_ARBITER_RR_EN
    assign rr_en = 1'b1;
`else
    // Pointer is fixed at "port 1 last" so port 0 always wins a tie.
    assign rr_en    = 1'b0;
    assign last_reg = 1'b1;
`endif

    imem_arb_pick u_pick (
        .req   ({i_req1, i_req0}),
        .last  (last_reg),
        .rr_en (rr_en),
        .grant (pick_grant)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            mem_addr_reg <= '0;
            mem_read_reg <= 1'b0;
            grant_reg    <= 2'b00;
`ifdef IMEM_ARBITER_RR_EN
            last_reg     <= 1'b1;
`endif
        end else begin
            case (state_reg)
                IDLE, GAP: begin
                    // GAP keeps read low for this cycle; a stray repeated done is ignored here.
                    if (|pick_grant) begin
                        state_reg    <= BUSY;
                        mem_read_reg <= 1'b1;
                        mem_addr_reg <= pick_grant[PORT_FETCH] ? i_addr0 : i_addr1;
                        grant_reg    <= pick_grant;
`ifdef IMEM_ARBITER_RR_EN
                        last_reg     <= pick_grant[PORT_DEBUG];
`endif
                    end else begin
                        state_reg    <= IDLE;
                        mem_read_reg <= 1'b0;
                        grant_reg    <= 2'b00;
                    end
                end
                BUSY: begin
                    if (i_mem_done) begin
                        state_reg    <= GAP;
                        mem_read_reg <= 1'b0;
                        grant_reg    <= 2'b00;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    mem_read_reg <= 1'b0;
                    grant_reg    <= 2'b00;
                end
            endcase
        end
    end

    assign o_done0    = (state_reg == BUSY) && grant_reg[PORT_FETCH] && i_mem_done;
    assign o_done1    = (state_reg == BUSY) && grant_reg[PORT_DEBUG] && i_mem_done;
    assign o_data0    = i_mem_data;
    assign o_data1    = i_mem_data;
    assign o_mem_addr = mem_addr_reg;
    assign o_mem_read = mem_read_reg;
    assign o_grant    = grant_reg;

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter with a 3-cycle imemory model that repeats done once.
module tb_imem_arbiter;

    localparam int AW = 15;
    localparam int DW = 48;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req0, req1;
    logic [AW-1:0] addr0, addr1;
    logic          done0, done1;
    logic [DW-1:0] data0, data1;
    logic [AW-1:0] mem_addr;
    logic          mem_read;
    logic [DW-1:0] mem_data;
    logic          mem_done;
    logic [1:0]    grant;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic          port;
        logic [DW-1:0] data;
    } sb_entry_t;
    sb_entry_t sb_q[$];

    always #5 clk = ~clk;

    imem_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_req0     (req0),
        .i_addr0    (addr0),
        .o_done0    (done0),
        .o_data0    (data0),
        .i_req1     (req1),
        .i_addr1    (addr1),
        .o_done1    (done1),
        .o_data1    (data1),
        .o_mem_addr (mem_addr),
        .o_mem_read (mem_read),
        .i_mem_data (mem_data),
        .i_mem_done (mem_done),
        .o_grant    (grant)
    );

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        if (a == 15'h0010) return 48'h123456789ABC;
        return {a, 1'b1, ~a, 17'h0A5A5};
    endfunction

    // imemory model: done in the third read-high cycle, repeated once after read drops.
    int   mem_cnt = 0;
    logic mem_rpt = 1'b0;
    always @(posedge clk) begin
        mem_cnt <= mem_read ? mem_cnt + 1 : 0;
        mem_rpt <= mem_read && (mem_cnt == 2);
    end
    assign mem_done = (mem_read && (mem_cnt == 2)) || mem_rpt;
    assign mem_data = mem_word(mem_addr);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic port, input logic [AW-1:0] a);
        sb_q.push_back('{port: port, data: mem_word(a)});
    endtask

    // Monitor: every done pulse pops the scoreboard.
    always @(negedge clk) begin
        if (reset_n && (done0 || done1)) begin
            sb_entry_t e;
            check("done_both", {63'd0, done0 && done1}, 64'd0);
            if (sb_q.size() == 0) begin
                check("sb_unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("sb_port", {63'd0, done1}, {63'd0, e.port});
                check("sb_data", {16'd0, done1 ? data1 : data0}, {16'd0, e.data});
                $display("[TB] done port=%0d data=%h grant=%b", done1, done1 ? data1 : data0, grant);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
    endtask

    initial begin
        addr0 = '0; addr1 = '0;
        do_reset();
        @(negedge clk);
        check("rst_read",  {63'd0, mem_read}, 64'd0);
        check("rst_grant", {62'd0, grant}, 64'd0);
        check("rst_addr",  {49'd0, mem_addr}, 64'd0);
        check("rst_done",  {62'd0, done1, done0}, 64'd0);
        next_cycle();

        // Single fetch
        req0 = 1'b1; addr0 = 15'h0010; push(1'b0, 15'h0010);
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            check("t1_read",  {63'd0, mem_read}, {63'd0, (c >= 1 && c <= 3)});
            check("t1_done0", {63'd0, done0}, {63'd0, c == 3});
            check("t1_done1", {63'd0, done1}, 64'd0);
            if (c == 3) req0 = 1'b0;
            next_cycle();
        end

        // Gap enforcement: three back-to-back accesses
        req0 = 1'b1; addr0 = 15'd0; push(1'b0, 15'd0);
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            check("t2_read",  {63'd0, mem_read}, {63'd0, (c >= 1 && c <= 11 && (c % 4) != 0)});
            check("t2_done0", {63'd0, done0}, {63'd0, (c == 3 || c == 7 || c == 11)});
            if (c == 3) begin addr0 = 15'd1; push(1'b0, 15'd1); end
            if (c == 7) begin addr0 = 15'd2; push(1'b0, 15'd2); end
            if (c == 11) req0 = 1'b0;
            next_cycle();
        end

        // Tie, from reset: port 0 first then port 1 in either mode
        do_reset();
        req0 = 1'b1; addr0 = 15'h0020; req1 = 1'b1; addr1 = 15'h0030;
        push(1'b0, 15'h0020); push(1'b1, 15'h0030);
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) check("t3_grant_a", {62'd0, grant}, 64'd1);
            if (c == 4) check("t3_grant_gap", {62'd0, grant}, 64'd0);
            if (c == 5) check("t3_grant_b", {62'd0, grant}, 64'd2);
            if (c == 2) check("t3_addr_a", {49'd0, mem_addr}, 64'h20);
            if (c == 6) check("t3_addr_b", {49'd0, mem_addr}, 64'h30);
            if (c == 3) req0 = 1'b0;
            if (c == 7) req1 = 1'b0;
            next_cycle();
        end

        // Tie held for four accesses
        do_reset();
        req0 = 1'b1; addr0 = 15'h0040; req1 = 1'b1; addr1 = 15'h0050;
        for (int k = 0; k < 4; k++) begin
`ifdef IMEM_ARBITER_RR_EN
            push(k[0], k[0] ? 15'h0050 : 15'h0040);
`else
            push(1'b0, 15'h0040);
`endif
        end
        for (int c = 0; c <= 16; c++) begin
            @(negedge clk);
            if (c % 4 == 1 && c < 16) begin
`ifdef IMEM_ARBITER_RR_EN
                check("t4_grant", {62'd0, grant}, ((c / 4) % 2 == 0) ? 64'd1 : 64'd2);
`else
                check("t4_grant", {62'd0, grant}, 64'd1);
`endif
            end
            if (c == 15) begin req0 = 1'b0; req1 = 1'b0; end
            next_cycle();
        end

        // Address change while granted is ignored
        req0 = 1'b1; addr0 = 15'h0005; push(1'b0, 15'h0005);
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            if (c == 2) addr0 = 15'h0777;
            if (c == 2 || c == 3) check("t5_addr", {49'd0, mem_addr}, 64'h5);
            if (c == 3) req0 = 1'b0;
            next_cycle();
        end

        // Reset mid-access, then a fresh port 1 request
        req0 = 1'b1; addr0 = 15'h0060;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            if (c == 2) reset_n = 1'b0;
            if (c == 3) begin
                check("t6_read",  {63'd0, mem_read}, 64'd0);
                check("t6_grant", {62'd0, grant}, 64'd0);
                check("t6_done",  {62'd0, done1, done0}, 64'd0);
                reset_n = 1'b1;
                req0 = 1'b0;
            end
            next_cycle();
        end
        req1 = 1'b1; addr1 = 15'h0070; push(1'b1, 15'h0070);
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            check("t6_read2",  {63'd0, mem_read}, {63'd0, (c >= 1 && c <= 3)});
            check("t6_done1",  {63'd0, done1}, {63'd0, c == 3});
            check("t6_done0",  {63'd0, done0}, 64'd0);
            if (c == 1) check("t6_grant2", {62'd0, grant}, 64'd2);
            if (c == 3) req1 = 1'b0;
            next_cycle();
        end

        next_cycle();
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
